// File: rtl/ysyx_23060077_riscv_assoc_lut_if.sv
// Lookup, response and write channels of the associative table.
// The master drives requests, writes and flush; the slave is the table itself.
interface ysyx_23060077_riscv_assoc_lut_if #(
   parameter int unsigned KEY_LEN  = 8,
   parameter int unsigned DATA_LEN = 32,
   parameter int unsigned CNT_W    = 3
);
   logic                req_valid;
   logic                req_ready;
   logic [KEY_LEN-1:0]  req_key;
   logic [DATA_LEN-1:0] default_out;
   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_hit;
   logic [DATA_LEN-1:0] rsp_data;
   logic                wr_en;
   logic [KEY_LEN-1:0]  wr_key;
   logic [DATA_LEN-1:0] wr_data;
   logic                flush;
   logic [CNT_W-1:0]    occupancy;

   modport master (
      output req_valid, req_key, default_out, rsp_ready,
      output wr_en, wr_key, wr_data, flush,
      input  req_ready, rsp_valid, rsp_hit, rsp_data, occupancy
   );

   modport slave (
      input  req_valid, req_key, default_out, rsp_ready,
      input  wr_en, wr_key, wr_data, flush,
      output req_ready, rsp_valid, rsp_hit, rsp_data, occupancy
   );
endinterface

// File: rtl/ysyx_23060077_riscv_assoc_lut.sv
// Registered, writable key/data associative table with a one-stage
// valid/ready lookup pipeline, single-port write (update/allocate/replace)
// and whole-table flush.
module ysyx_23060077_riscv_assoc_lut #(
   parameter int unsigned NR_KEY      = 4,
   parameter int unsigned KEY_LEN     = 8,
   parameter int unsigned DATA_LEN    = 32,
   parameter bit          HAS_DEFAULT = 1'b0,
   parameter int unsigned CNT_W       = $clog2(NR_KEY + 1)
) (
   input  logic clk,
   input  logic rst,
   ysyx_23060077_riscv_assoc_lut_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(NR_KEY);

   logic [NR_KEY-1:0]   valid;
   logic [KEY_LEN-1:0]  keys  [NR_KEY];
   logic [DATA_LEN-1:0] datas [NR_KEY];
   logic [IDX_W-1:0]    victim;
   logic [CNT_W-1:0]    occ;

   logic                rsp_valid_q;
   logic                rsp_hit_q;
   logic [DATA_LEN-1:0] rsp_data_q;

   logic                lk_hit;
   logic [DATA_LEN-1:0] lk_data;
   logic                wr_hit;
   logic [IDX_W-1:0]    wr_idx;
   logic                free_found;
   logic [IDX_W-1:0]    free_idx;
   logic                accept;

   assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_hit   = rsp_hit_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.occupancy = occ;

   assign accept = bus.req_valid && bus.req_ready;

   // Lookup match against the current table; keys are unique so an OR-merge suffices.
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      for (int unsigned i = 0; i < NR_KEY; i++) begin
         if (valid[i] && keys[i] == bus.req_key) begin
            lk_hit  = 1'b1;
            lk_data = lk_data | datas[i];
         end
      end
   end

   // Write-side decode: matching entry and lowest-index free slot.
   always_comb begin
      wr_hit     = 1'b0;
      wr_idx     = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < NR_KEY; i++) begin
         if (valid[i] && keys[i] == bus.wr_key) begin
            wr_hit = 1'b1;
            wr_idx = IDX_W'(i);
         end
         if (!valid[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Response register: load on accept, drop once consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_hit_q   <= lk_hit;
         if (lk_hit) begin
            rsp_data_q <= lk_data;
         end else if (HAS_DEFAULT) begin
            rsp_data_q <= bus.default_out;
         end else begin
            rsp_data_q <= '0;
         end
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   // Table state: flush beats write; full-table miss replaces at the victim pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid  <= '0;
         victim <= '0;
         occ    <= '0;
      end else if (bus.flush) begin
         valid  <= '0;
         victim <= '0;
         occ    <= '0;
      end else if (bus.wr_en) begin
         if (wr_hit) begin
            datas[wr_idx] <= bus.wr_data;
         end else if (free_found) begin
            valid[free_idx] <= 1'b1;
            keys[free_idx]  <= bus.wr_key;
            datas[free_idx] <= bus.wr_data;
            occ             <= occ + CNT_W'(1);
         end else begin
            keys[victim]  <= bus.wr_key;
            datas[victim] <= bus.wr_data;
            if (victim == IDX_W'(NR_KEY - 1)) begin
               victim <= '0;
            end else begin
               victim <= victim + IDX_W'(1);
            end
         end
      end
   end
endmodule

// File: doc/ysyx_23060077_riscv_assoc_lut.md
Name: ysyx_23060077_riscv_assoc_lut

Overview:
A registered, writable key/data associative table that generalises the combinational key mux into a runtime-programmable lookup.
- Holds NR_KEY entries. Each entry is a valid bit, a key and a data word.
- Serves one lookup per cycle through a one-stage valid/ready pipeline.
- Accepts one write (update or allocate) per cycle.
- Provides a whole-table flush.
- Used by decode/LSU helpers that need small runtime-programmable key→value maps, e.g. CSR shadow or address-attribute tables.

Parameters:
NR_KEY, 4, number of entries (≥2)
KEY_LEN, 8, key width in bits
DATA_LEN, 32, data width in bits
HAS_DEFAULT, 0, 1: a miss returns the sampled default_out; 0: a miss returns all-zero data
CNT_W, $clog2(NR_KEY+1), width of the occupancy count

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  lookup request valid
req_ready  output  1  lookup request accepted when req_valid and req_ready are both high
req_key  input  KEY_LEN  lookup key
default_out  input  DATA_LEN  miss value; sampled with the request
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts the response
rsp_hit  output  1  response key matched a valid entry
rsp_data  output  DATA_LEN  response data
wr_en  input  1  write strobe
wr_key  input  KEY_LEN  write key
wr_data  input  DATA_LEN  write data
flush  input  1  invalidate all entries
occupancy  output  CNT_W  number of valid entries

Behaviour:
Reset (rst high at a clock edge) clears:
- all valid bits
- victim pointer → 0
- rsp_valid, rsp_hit, rsp_data → 0
- occupancy → 0

req_ready:
- req_ready = !rsp_valid || rsp_ready (combinational).
- req_ready is 1 in the cycle after reset.

Lookup:
- A request accepted in cycle t compares req_key against all valid entries, using table contents as of the start of cycle t.
- A write or flush in the same cycle t is not visible to that lookup.
- rsp_valid rises in cycle t+1 (1-cycle latency).
- On hit: rsp_hit=1 and rsp_data = data of the matching entry.
- On miss: rsp_hit=0 and rsp_data = default_out sampled at t if HAS_DEFAULT, else 0.
- Keys are unique by construction (see write rules), so at most one entry can match.

Response hold:
- While rsp_valid=1 and rsp_ready=0, rsp_hit and rsp_data stay stable and req_ready=0.
- If rsp_ready=1 and no new request is accepted, rsp_valid falls next cycle.
- A back-to-back request is accepted in the same cycle the response is consumed, giving full throughput.

Write, when wr_en=1 and flush=0:
- Hit: the wr_key matches a valid entry → overwrite that entry's data. No allocation; victim pointer unchanged.
- Miss with a free entry: allocate the lowest-index invalid entry (valid←1, key, data). Occupancy increments.
- Miss with the table full: replace the entry at the victim pointer. The pointer then increments, wrapping NR_KEY-1 → 0. Occupancy unchanged.
- The victim pointer advances only on full-table replacement.

Flush:
- flush=1 clears all valid bits and sets the victim pointer and occupancy to 0 at the edge.
- flush has priority: a simultaneous wr_en is dropped.
- A lookup accepted in the same cycle still uses the pre-flush contents.
- An in-flight response is unaffected by flush.

Reset mid-operation:
- Any pending response is dropped (rsp_valid→0).
- Writes and flush in the same cycle are ignored.

occupancy:
- Registered; equals the popcount of the valid bits at all times.

Test Plan:
- After reset: occupancy=0, rsp_valid=0, req_ready=1. Lookup key 0x12 with HAS_DEFAULT=1, default_out=0xDEAD → next cycle rsp_valid=1, rsp_hit=0, rsp_data=0xDEAD. Repeat with HAS_DEFAULT=0 → rsp_data=0.
- Write (0x12→0xAAAA), then lookup 0x12 → rsp_hit=1, rsp_data=0xAAAA. Write (0x12→0xBBBB) → occupancy stays 1 and the lookup returns 0xBBBB.
- Fill 4 distinct keys K0..K3 → occupancy=4. Write K4 → replaces entry 0 (K0 now misses, K4 hits). Write K5 → replaces entry 1. Keep writing new keys until the victim pointer wraps back to 0.
- In the same cycle: write (0x34→0x5555) and lookup 0x34 on an empty table → miss. The following lookup → hit 0x5555.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 → req_ready=0 and rsp_data stable. Release → streaming lookups for keys A, B, C return one response per cycle in order.
- Flush and wr_en together with table occupancy 3 → occupancy=0, all lookups miss, write dropped. Assert rst while rsp_valid=1 → rsp_valid=0 next cycle.
